// File: rtl/ser_dispatch_if.sv
// Table-entry payload type and the buffer/engine-side bundle of the field dispatcher.
// The dispatcher attaches through the master modport; buffer and engines use slave.
package ser_dispatch_pkg;
    typedef struct packed {
        logic        nested;
        logic [6:0]  wire_type;
        logic [7:0]  field_id;
        logic [15:0] offset;
    } table_entry_t;
endpackage

interface ser_dispatch_if #(parameter int unsigned NUM_SER = 4);
    import ser_dispatch_pkg::*;

    table_entry_t       buf_entry;
    logic               buf_entry_valid;
    logic               buf_top_end;
    logic [63:0]        buf_cpp_base_addr;
    logic               ser_ready;
    logic               ser_done;
    logic [NUM_SER-1:0] eng_start;
    table_entry_t       eng_entry;
    logic [63:0]        eng_base_addr;
    logic [NUM_SER-1:0] eng_done;
    logic [NUM_SER-1:0] eng_ack;

    modport master (
        input  buf_entry, buf_entry_valid, buf_top_end, buf_cpp_base_addr, eng_done,
        output ser_ready, ser_done, eng_start, eng_entry, eng_base_addr, eng_ack
    );

    modport slave (
        output buf_entry, buf_entry_valid, buf_top_end, buf_cpp_base_addr, eng_done,
        input  ser_ready, ser_done, eng_start, eng_entry, eng_base_addr, eng_ack
    );
endinterface

// File: rtl/ser_dispatch.sv
// Pulls object-buffer entries in order, issues field entries round-robin to serializer
// engines and retires engine completions strictly in issue order.
module ser_dispatch
    import ser_dispatch_pkg::*;
#(
    parameter int unsigned NUM_SER = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    ser_dispatch_if.master   bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issued_cnt
);
    localparam int unsigned IDX_W = (NUM_SER > 1) ? $clog2(NUM_SER) : 1;
    localparam int unsigned OCC_W = $clog2(NUM_SER + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SER - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_SETTLE, S_DRAIN, S_FIN} state_t;

    state_t             r_state, w_next;
    logic [NUM_SER-1:0] r_busy_vec;
    logic [IDX_W-1:0]   r_rr, r_wr_ptr, r_rd_ptr;
    logic [IDX_W-1:0]   r_fifo [NUM_SER];
    logic [OCC_W-1:0]   r_occ;
    logic [CNT_W-1:0]   r_issued_cnt;

    logic               w_found;
    logic [IDX_W-1:0]   w_sel, w_cand, w_head;
    logic               w_head_ctrl, w_retire, w_issue, w_ser_done;
    logic [NUM_SER-1:0] w_start_mask, w_ack_mask, w_busy_nxt;
    logic [OCC_W-1:0]   w_occ_nxt;
    table_entry_t       w_eng_entry;
    logic [63:0]        w_eng_base;

    // First free engine at or after the round-robin pointer, scanning upward with wrap
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NUM_SER; i++) begin
            w_cand = IDX_W'((32'(r_rr) + i) % NUM_SER);
            if (!w_found && !r_busy_vec[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_head_ctrl = bus.buf_entry.nested || (bus.buf_entry.field_id == 8'd0);
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_retire    = (r_occ != '0) && bus.eng_done[w_head];
    assign w_ack_mask  = w_retire ? (NUM_SER'(1) << w_head) : '0;
    assign w_busy_nxt  = (r_busy_vec | w_start_mask) & ~w_ack_mask;
    assign w_occ_nxt   = r_occ + OCC_W'(w_issue) - OCC_W'(w_retire);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // DRAIN looks at post-retirement occupancy so the last ack moves straight to FIN
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_RUN;
            S_RUN: begin
                if (bus.buf_entry_valid) begin
                    if (bus.buf_top_end)   w_next = S_DRAIN;
                    else if (w_head_ctrl)  w_next = S_SETTLE;
                    else if (w_found)      w_next = S_SETTLE;
                end
            end
            S_SETTLE: w_next = S_RUN;
            S_DRAIN:  if ((w_occ_nxt == '0) && (w_busy_nxt == '0)) w_next = S_FIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue      = 1'b0;
        w_ser_done   = 1'b0;
        w_start_mask = '0;
        w_eng_entry  = '0;
        w_eng_base   = '0;
        if ((r_state == S_RUN) && bus.buf_entry_valid) begin
            if (bus.buf_top_end || w_head_ctrl) begin
                w_ser_done = 1'b1;
            end else if (w_found) begin
                w_issue      = 1'b1;
                w_ser_done   = 1'b1;
                w_start_mask = NUM_SER'(1) << w_sel;
                w_eng_entry  = bus.buf_entry;
                w_eng_base   = bus.buf_cpp_base_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy_vec   <= '0;
            r_rr         <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_occ        <= '0;
            r_issued_cnt <= '0;
        end else begin
            r_busy_vec <= w_busy_nxt;
            r_occ      <= w_occ_nxt;
            if (w_issue) begin
                r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
                r_rr     <= (w_sel == LAST_IDX) ? '0 : w_sel + 1'b1;
            end
            if (w_retire)
                r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
            if ((r_state == S_IDLE) && start)
                r_issued_cnt <= '0;
            else if (w_issue && !(&r_issued_cnt))
                r_issued_cnt <= r_issued_cnt + 1'b1;
        end
    end

    // Retire-order storage; only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (w_issue) r_fifo[r_wr_ptr] <= w_sel;
    end

    assign bus.ser_done      = w_ser_done;
    assign bus.eng_start     = w_start_mask;
    assign bus.eng_entry     = w_eng_entry;
    assign bus.eng_base_addr = w_eng_base;
    assign bus.eng_ack       = w_ack_mask;
    assign bus.ser_ready     = (r_state == S_RUN) && !(&r_busy_vec);
    assign busy              = (r_state != S_IDLE);
    assign done              = (r_state == S_FIN);
    assign issued_cnt        = r_issued_cnt;
endmodule

// File: tb/tb_ser_dispatch.sv
// Directed bench for ser_dispatch: issue, settle, control entries, in-order retire, reset.
module tb_ser_dispatch;
    import ser_dispatch_pkg::*;

    localparam int unsigned N = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic [15:0] issued_cnt;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    ser_dispatch_if #(.NUM_SER(N)) bus();

    ser_dispatch #(.NUM_SER(N), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        #2;
    endtask

    task automatic head(input logic v, input logic te, input logic [7:0] fid,
                        input logic nst, input logic [63:0] base);
        bus.buf_entry_valid   = v;
        bus.buf_top_end       = te;
        bus.buf_entry         = '{nested: nst, wire_type: 7'd0, field_id: fid, offset: {8'h00, fid}};
        bus.buf_cpp_base_addr = base;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 64'({busy, done, bus.ser_ready, bus.ser_done, bus.eng_start,
                                bus.eng_ack, issued_cnt}), 64'd0);
        chk({tag, "_base"}, bus.eng_base_addr, 64'd0);
        chk({tag, "_entry"}, 64'(bus.eng_entry), 64'd0);
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        start = 1'b0;
        head(1'b0, 1'b0, 8'd0, 1'b0, 64'd0);
        bus.eng_done = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        head(1'b0, 1'b0, 8'd0, 1'b0, 64'd0);
        bus.eng_done = '0;
        rst_n = 1'b0;
        step(); smp();
        chk_zero("por");
        rst_n = 1'b1;

        // single field, then top end
        step(); start = 1'b1; smp();
        chk("t1_idle_busy", 64'(busy), 64'd0);
        step(); start = 1'b0; head(1'b1, 1'b0, 8'd3, 1'b0, 64'h100); smp();
        chk("t1_eng_start", 64'(bus.eng_start), 64'h1);
        chk("t1_base", bus.eng_base_addr, 64'h100);
        chk("t1_entry", 64'(bus.eng_entry), 64'h0003_0003);
        chk("t1_ser_done", 64'(bus.ser_done), 64'd1);
        chk("t1_ready", 64'(bus.ser_ready), 64'd1);
        step(); smp();
        chk("t1_settle_start", 64'(bus.eng_start), 64'd0);
        chk("t1_settle_sdone", 64'(bus.ser_done), 64'd0);
        chk("t1_settle_ready", 64'(bus.ser_ready), 64'd0);
        step(); head(1'b1, 1'b1, 8'd0, 1'b0, 64'd0); start = 1'b1; smp();
        chk("t1_top_sdone", 64'(bus.ser_done), 64'd1);
        chk("t1_top_start", 64'(bus.eng_start), 64'd0);
        chk("t1_cnt", 64'(issued_cnt), 64'd1);
        step(); start = 1'b0; head(1'b0, 1'b0, 8'd0, 1'b0, 64'd0); smp();
        chk("t1_ign_start_cnt", 64'(issued_cnt), 64'd1);
        chk("t1_drain_ack", 64'(bus.eng_ack), 64'd0);
        chk("t1_drain_done", 64'(done), 64'd0);
        step(); bus.eng_done = 4'b0001; smp();
        chk("t1_ack", 64'(bus.eng_ack), 64'h1);
        chk("t1_ack_done", 64'(done), 64'd0);
        step(); bus.eng_done = 4'b0000; smp();
        chk("t1_fin_done", 64'(done), 64'd1);
        chk("t1_fin_ack", 64'(bus.eng_ack), 64'd0);
        step(); smp();
        chk("t1_end_done", 64'(done), 64'd0);
        chk("t1_end_busy", 64'(busy), 64'd0);
        chk("t1_end_cnt", 64'(issued_cnt), 64'd1);

        // control entries only
        step(); start = 1'b1; smp();
        step(); start = 1'b0; head(1'b1, 1'b0, 8'd7, 1'b1, 64'h200); smp();
        chk("t4_nest_sdone", 64'(bus.ser_done), 64'd1);
        chk("t4_nest_start", 64'(bus.eng_start), 64'd0);
        chk("t4_cnt_clr", 64'(issued_cnt), 64'd0);
        step(); smp();
        chk("t4_settle1", 64'(bus.ser_done), 64'd0);
        step(); head(1'b1, 1'b0, 8'd0, 1'b0, 64'h300); smp();
        chk("t4_end_sdone", 64'(bus.ser_done), 64'd1);
        chk("t4_end_start", 64'(bus.eng_start), 64'd0);
        step(); smp();
        chk("t4_settle2", 64'(bus.ser_done), 64'd0);
        step(); head(1'b1, 1'b1, 8'd0, 1'b0, 64'd0); smp();
        chk("t4_top_sdone", 64'(bus.ser_done), 64'd1);
        step(); head(1'b0, 1'b0, 8'd0, 1'b0, 64'd0); smp();
        chk("t4_drain_done", 64'(done), 64'd0);
        chk("t4_drain_busy", 64'(busy), 64'd1);
        step(); smp();
        chk("t4_fin_done", 64'(done), 64'd1);
        chk("t4_cnt", 64'(issued_cnt), 64'd0);
        step(); smp();
        chk("t4_idle_busy", 64'(busy), 64'd0);

        // out-of-order completion retired in issue order
        do_reset();
        step(); start = 1'b1; smp();
        step(); start = 1'b0; head(1'b1, 1'b0, 8'd1, 1'b0, 64'h10); smp();
        chk("t3_start0", 64'(bus.eng_start), 64'h1);
        step(); smp();
        step(); head(1'b1, 1'b0, 8'd2, 1'b0, 64'h20); smp();
        chk("t3_start1", 64'(bus.eng_start), 64'h2);
        chk("t3_base1", bus.eng_base_addr, 64'h20);
        step(); smp();
        step(); head(1'b1, 1'b1, 8'd0, 1'b0, 64'd0); bus.eng_done = 4'b0010; smp();
        chk("t3_hold_a", 64'(bus.eng_ack), 64'd0);
        step(); head(1'b0, 1'b0, 8'd0, 1'b0, 64'd0); smp();
        chk("t3_hold_b", 64'(bus.eng_ack), 64'd0);
        step(); smp();
        chk("t3_hold_c", 64'(bus.eng_ack), 64'd0);
        step(); bus.eng_done = 4'b0011; smp();
        chk("t3_ack0", 64'(bus.eng_ack), 64'h1);
        step(); bus.eng_done = 4'b0010; smp();
        chk("t3_ack1", 64'(bus.eng_ack), 64'h2);
        chk("t3_ack1_done", 64'(done), 64'd0);
        step(); bus.eng_done = 4'b0000; smp();
        chk("t3_fin_done", 64'(done), 64'd1);
        step(); smp();
        chk("t3_idle_busy", 64'(busy), 64'd0);

        // round robin until every engine is busy
        do_reset();
        step(); start = 1'b1; smp();
        step(); start = 1'b0; head(1'b1, 1'b0, 8'd5, 1'b0, 64'h500);
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("t2_start%0d", k), 64'(bus.eng_start), 64'(4'b0001 << k));
            chk($sformatf("t2_sdone%0d", k), 64'(bus.ser_done), 64'd1);
            step(); smp();
            chk($sformatf("t2_settle%0d", k), 64'(bus.eng_start), 64'd0);
            step();
        end
        smp();
        chk("t2_stall_start", 64'(bus.eng_start), 64'd0);
        chk("t2_stall_sdone", 64'(bus.ser_done), 64'd0);
        chk("t2_stall_ready", 64'(bus.ser_ready), 64'd0);
        step(); smp();
        chk("t2_stall2_sdone", 64'(bus.ser_done), 64'd0);
        chk("t2_cnt", 64'(issued_cnt), 64'd4);

        // asynchronous reset with three engines in flight
        do_reset();
        step(); start = 1'b1; smp();
        step(); start = 1'b0; head(1'b1, 1'b0, 8'd9, 1'b0, 64'h900);
        for (int k = 0; k < 3; k++) begin
            smp();
            chk($sformatf("t5_start%0d", k), 64'(bus.eng_start), 64'(4'b0001 << k));
            step();
            if (k != 2) step();
        end
        bus.eng_done = 4'b0001; smp();
        chk("t5_pre_ack", 64'(bus.eng_ack), 64'h1);
        chk("t5_pre_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("t5_rst");
        step(); rst_n = 1'b1; bus.eng_done = 4'b0000; smp();
        chk("t5_idle_busy", 64'(busy), 64'd0);
        chk("t5_idle_start", 64'(bus.eng_start), 64'd0);
        step(); start = 1'b1; smp();
        step(); start = 1'b0; smp();
        chk("t5_restart_eng0", 64'(bus.eng_start), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ser_dispatch.md
# ser_dispatch

Sequencing controller between the object buffer and a pool of `NUM_SER` field serializer engines. It pulls entries from the buffer head in order and consumes control entries (nested-object openers, end markers) itself. Plain field entries go round-robin to free engines, tagged with the current C++ base address. Engine completions are retired strictly in issue order, so serialized output bytes stay in table order.

## Interface
Parameters:
- `NUM_SER`, 4: number of serializer engines (2..8).
- `CNT_W`, 16: width of the issued-entry statistics counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a message; ignored unless in IDLE.
- `buf_entry` in TABLE_ENTRY: head entry of the object buffer.
- `buf_entry_valid` in 1: `buf_entry` is valid.
- `buf_top_end` in 1: head entry is the top-level end marker; qualified by `buf_entry_valid`.
- `buf_cpp_base_addr` in 64: base address for the head entry.
- `ser_ready` out 1: dispatcher is in RUN and at least one engine is free.
- `ser_done` out 1: one-cycle pulse; the buffer head is consumed.
- `eng_start` out NUM_SER: one-hot start pulse.
- `eng_entry` out TABLE_ENTRY: entry for the started engine; valid only with `eng_start`.
- `eng_base_addr` out 64: base address for the started engine.
- `eng_done` in NUM_SER: level signal; the engine has finished and is holding its output.
- `eng_ack` out NUM_SER: one-hot pulse that retires an engine and releases its output.
- `busy` out 1: state is not IDLE.
- `done` out 1: registered one-cycle pulse marking message complete.
- `issued_cnt` out CNT_W: number of field entries issued since the last `start`; saturates at all ones.

## Operation
- The FSM has five states: IDLE, RUN, SETTLE, DRAIN, FIN. Reset enters IDLE.
- **IDLE:** on `start`, clear `issued_cnt`, go to RUN.
- **RUN:** acts on the head only when `buf_entry_valid`=1. Priority order:
  1. `buf_top_end`=1: pulse `ser_done`, go to DRAIN.
  2. Control entry (`entry.nested`=1 or `entry.field_id`=0): pulse `ser_done`, go to SETTLE. No engine is used.
  3. Field entry with a free engine: select engine k, the first free engine at or after round-robin pointer `rr`, scanning upward with wrap.
     - Pulse `eng_start[k]`, drive `eng_entry`=`buf_entry` and `eng_base_addr`=`buf_cpp_base_addr`.
     - Set `busy_vec[k]`, push k into the retire FIFO, pulse `ser_done`.
     - Set `rr` = (k+1) mod NUM_SER, increment `issued_cnt`, go to SETTLE.
  4. Field entry with no free engine: stall in RUN; `ser_done`=0.
- **SETTLE:** lasts exactly one cycle and issues nothing, because the buffer head, valid and base address update one cycle after `ser_done`. Then return to RUN.
- **DRAIN:** wait until the retire FIFO is empty and `busy_vec`=0, then go to FIN.
- **FIN:** `done`=1 for one cycle, then go to IDLE.
- **Retirement** runs in every state, independent of the FSM.
  - Let h be the head of the retire FIFO. If the FIFO is non-empty and `eng_done[h]`=1: pulse `eng_ack[h]`, clear `busy_vec[h]`, pop.
  - At most one retirement per cycle. A completion from a non-head engine waits.
  - A retirement and an issue in the same cycle are legal: push and pop together.
  - The engine freed by a retirement becomes selectable the following cycle.
- **Retire FIFO:** depth NUM_SER, log2 pointers with wrap. It cannot overflow, because issue requires a free engine.
- **Output timing:** `ser_done`, `eng_start`, `eng_entry`, `eng_base_addr`, `eng_ack` are combinational from state and inputs. `done`, `busy`, `ser_ready`, `issued_cnt` are registered or decoded from registers.
- **Reset:** while `reset`=0, every output is 0 immediately. State is IDLE; `rr`, `busy_vec`, FIFO pointers and `issued_cnt` are 0.
  - Reset mid-message abandons in-flight engines.
  - The engines and the buffer share this reset.

## Timing
- Issue throughput is one head entry per 2 cycles (RUN + SETTLE) when engines are available.
- `start` to first possible `ser_done` is 1 cycle: `start` at cycle t, RUN at t+1.
- `eng_done[h]` high at cycle t produces `eng_ack[h]` at cycle t.
- The last ack at cycle t gives DRAIN→FIN at t+1 and `done` high during t+1.
- A `start` pulse in any state other than IDLE is ignored.

## Test plan
- **Single field:** `start`; head = field (`field_id`=3, `nested`=0, base 0x100); engine 0 raises `eng_done` 5 cycles after start; then top end.
  - Expect `eng_start`=0001 with `eng_base_addr`=0x100, then `ser_done`, then one SETTLE cycle.
  - Expect `eng_ack`=0001, then `done` 1 cycle after the last ack; `issued_cnt`=1.
- **Round robin, all busy:** 6 field entries, NUM_SER=4, engines never done.
  - Expect starts on engines 0,1,2,3 at cycles 1,3,5,7.
  - Expect the 5th entry stalls with `ser_done`=0 and `ser_ready`=0.
- **Out-of-order completion:** issue to engines 0 and 1; `eng_done[1]` rises 3 cycles before `eng_done[0]`.
  - Expect no `eng_ack` until `eng_done[0]` rises.
  - Then `eng_ack`=0001 and `eng_ack`=0010 on consecutive cycles.
- **Control entries:** head sequence nested(`field_id`=7, `nested`=1), end marker (`field_id`=0), top end.
  - Expect `ser_done` pulses 2 cycles apart with no `eng_start`; `issued_cnt`=0; `done` asserted.
- **Reset mid-message:** with 3 engines busy, drive `reset`=0 asynchronously between clock edges.
  - Expect all outputs 0 immediately; after release, state IDLE and the next issue goes to engine 0.
